// File: rtl/mem_responder.sv
// mem_responder: memory end of a multi-channel valid/ready read/write protocol.
// Holds 2^ADDR_BITS words of DATA_BITS each. Every channel runs its own
// IDLE -> WAIT -> RESPOND -> DRAIN handshake with a fixed response latency.
// A backdoor load port writes memory directly, independent of the channels.
//
// Ports:
//   clk, reset (async, active-low)
//   mem_read_valid/address   -> mem_read_ready/data    per-channel reads
//   mem_write_valid/address/data -> mem_write_ready    per-channel writes
//   load_enable/address/data  backdoor write, ignored while reset=0
//   busy                      high while any channel is not IDLE
module mem_responder #(
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned WRITE_ENABLE = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready,
  input  logic                              load_enable,
  input  logic [ADDR_BITS-1:0]              load_address,
  input  logic [DATA_BITS-1:0]              load_data,
  output logic                              busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND, S_DRAIN} state_e;
  typedef enum logic {K_READ, K_WRITE} kind_e;

  localparam int unsigned DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  state_e               state_q [NUM_CHANNELS];
  state_e               state_d [NUM_CHANNELS];
  kind_e                kind_q  [NUM_CHANNELS];
  kind_e                kind_d  [NUM_CHANNELS];
  logic [3:0]           cnt_q   [NUM_CHANNELS];
  logic [3:0]           cnt_d   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_d  [NUM_CHANNELS];
  // Holds the read sample taken at acceptance, or the write data to commit.
  logic [DATA_BITS-1:0] data_q  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] data_d  [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0]           read_ready_q, read_ready_d;
  logic [NUM_CHANNELS-1:0]           write_ready_q, write_ready_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0] read_data_q, read_data_d;
  logic [NUM_CHANNELS-1:0]           commit;
  logic [NUM_CHANNELS-1:0]           wr_valid;
  logic                              busy_c;

  assign wr_valid = (WRITE_ENABLE != 0) ? mem_write_valid : '0;

  always_comb begin
    read_ready_d  = '0;
    write_ready_d = '0;
    read_data_d   = read_data_q;
    commit        = '0;
    busy_c        = 1'b0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      kind_d[c]  = kind_q[c];
      cnt_d[c]   = cnt_q[c];
      addr_d[c]  = addr_q[c];
      data_d[c]  = data_q[c];
      if (state_q[c] != S_IDLE) busy_c = 1'b1;
      case (state_q[c])
        S_IDLE: begin
          if (mem_read_valid[c]) begin
            state_d[c] = S_WAIT;
            kind_d[c]  = K_READ;
            cnt_d[c]   = CNT_INIT;
            addr_d[c]  = mem_read_address[c*ADDR_BITS +: ADDR_BITS];
            // Sampled from pre-edge memory, so a same-edge commit is not seen.
            data_d[c]  = mem_q[mem_read_address[c*ADDR_BITS +: ADDR_BITS]];
          end else if (wr_valid[c]) begin
            state_d[c] = S_WAIT;
            kind_d[c]  = K_WRITE;
            cnt_d[c]   = CNT_INIT;
            addr_d[c]  = mem_write_address[c*ADDR_BITS +: ADDR_BITS];
            data_d[c]  = mem_write_data[c*DATA_BITS +: DATA_BITS];
          end
        end
        S_WAIT: begin
          if (cnt_q[c] == 4'd0) begin
            state_d[c] = S_RESPOND;
            if (kind_q[c] == K_READ) begin
              read_ready_d[c]                     = 1'b1;
              read_data_d[c*DATA_BITS +: DATA_BITS] = data_q[c];
            end else begin
              write_ready_d[c] = 1'b1;
              commit[c]        = 1'b1;
            end
          end else begin
            cnt_d[c] = cnt_q[c] - 4'd1;
          end
        end
        S_RESPOND: state_d[c] = S_DRAIN;
        S_DRAIN: begin
          if (kind_q[c] == K_READ) begin
            if (!mem_read_valid[c]) state_d[c] = S_IDLE;
          end else begin
            if (!wr_valid[c]) state_d[c] = S_IDLE;
          end
        end
        default: state_d[c] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= S_IDLE;
        kind_q[c]  <= K_READ;
        cnt_q[c]   <= '0;
        addr_q[c]  <= '0;
        data_q[c]  <= '0;
      end
      read_ready_q  <= '0;
      write_ready_q <= '0;
      read_data_q   <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        kind_q[c]  <= kind_d[c];
        cnt_q[c]   <= cnt_d[c];
        addr_q[c]  <= addr_d[c];
        data_q[c]  <= data_d[c];
      end
      read_ready_q  <= read_ready_d;
      write_ready_q <= write_ready_d;
      read_data_q   <= read_data_d;
    end
  end

  // Memory is never cleared. Later assignments win on a shared address:
  // higher channel index over lower, backdoor load over all channels.
  // commit is already 0 during reset since every channel is forced to IDLE.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (commit[c]) mem_q[addr_q[c]] <= data_q[c];
    end
    if (load_enable && reset) mem_q[load_address] <= load_data;
  end

  assign mem_read_ready  = read_ready_q;
  assign mem_write_ready = write_ready_q;
  assign mem_read_data   = read_data_q;
  assign busy            = busy_c;

endmodule
